// File: rtl/keypoint_merge_scheduler_pkg.sv
// Shared constants, field slices and FSM states for the keypoint merge scheduler.
package keypoint_merge_scheduler_pkg;

    localparam int unsigned KP_AW  = 11;
    localparam int unsigned KP_DW  = 19;
    localparam int unsigned KP_MAX = 2048;
    localparam int unsigned CNT_W  = 12;
    localparam int unsigned TOT_W  = 13;

    localparam int unsigned ROW_MSB = 18;
    localparam int unsigned ROW_LSB = 10;
    localparam int unsigned COL_MSB = 9;
    localparam int unsigned COL_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_MERGE,
        ST_DONE
    } state_t;

    // Entry counts above the SRAM depth are clamped to the depth.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(KP_MAX)) ? CNT_W'(KP_MAX) : c;
    endfunction

endpackage

// File: rtl/kp_list_reader.sv
// One keypoint list: remaining count, read pointer and a one-entry head buffer
// refilled from a 1-cycle-latency SRAM read port.
module kp_list_reader
    import keypoint_merge_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] count,
    input  logic             prime,
    input  logic             advance,
    input  logic             clear,
    input  logic [KP_DW-1:0] dout,
    output logic             re,
    output logic [KP_AW-1:0] addr,
    output logic [KP_DW-1:0] head,
    output logic             head_v,
    output logic             pending,
    output logic             exhausted
);

    logic [CNT_W-1:0] rem;
    logic [KP_AW-1:0] ptr;
    logic             more;

    // Read issue: first read at address 0 when priming, then the next address
    // each time the current head is consumed and entries remain behind it.
    always_comb begin
        more      = rem > CNT_W'(1);
        re        = (prime && rem != '0) || (advance && more);
        addr      = '0;
        if (re && !prime) begin
            addr = ptr + KP_AW'(1);
        end
        exhausted = (rem == '0) && !head_v && !pending;
    end

    // Counter, pointer, pending flag and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            ptr     <= '0;
            pending <= 1'b0;
            head    <= '0;
            head_v  <= 1'b0;
        end else if (clear) begin
            rem     <= '0;
            ptr     <= '0;
            pending <= 1'b0;
            head_v  <= 1'b0;
        end else if (load) begin
            rem     <= clamp_count(count);
            ptr     <= '0;
            pending <= 1'b0;
            head_v  <= 1'b0;
        end else begin
            if (pending) begin
                head    <= dout;
                head_v  <= 1'b1;
                pending <= 1'b0;
            end
            if (re) begin
                ptr     <= addr;
                pending <= 1'b1;
            end
            if (advance) begin
                rem <= rem - CNT_W'(1);
                if (!more) begin
                    head_v <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/keypoint_merge_scheduler.sv
// Merges two raster-ordered keypoint SRAM lists into one tagged stream.
module keypoint_merge_scheduler
    import keypoint_merge_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] kp1_count,
    input  logic [CNT_W-1:0] kp2_count,
    output logic             kp1_re,
    output logic [KP_AW-1:0] kp1_addr,
    input  logic [KP_DW-1:0] kp1_dout,
    output logic             kp2_re,
    output logic [KP_AW-1:0] kp2_addr,
    input  logic [KP_DW-1:0] kp2_dout,
    output logic             kp_valid,
    input  logic             kp_ready,
    output logic [KP_DW-1:0] kp_data,
    output logic             kp_layer,
    output logic [TOT_W-1:0] kp_total,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    logic             load, prime, clear, take, sel2;
    logic             adv1, adv2;
    logic [KP_DW-1:0] head1, head2;
    logic             hv1, hv2, pend1, pend2, exh1, exh2;

    kp_list_reader u_list1 (
        .clk(clk), .rst_n(rst_n), .load(load), .count(kp1_count),
        .prime(prime), .advance(adv1), .clear(clear), .dout(kp1_dout),
        .re(kp1_re), .addr(kp1_addr), .head(head1), .head_v(hv1),
        .pending(pend1), .exhausted(exh1)
    );

    kp_list_reader u_list2 (
        .clk(clk), .rst_n(rst_n), .load(load), .count(kp2_count),
        .prime(prime), .advance(adv2), .clear(clear), .dout(kp2_dout),
        .re(kp2_re), .addr(kp2_addr), .head(head2), .head_v(hv2),
        .pending(pend2), .exhausted(exh2)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state, list control, head selection and stream outputs.
    // kp_valid is masked by abort so a cancelled cycle never shows a handshake.
    always_comb begin
        state_nxt = state;
        load      = (state == ST_IDLE) && start && !abort;
        prime     = (state == ST_PRIME) && !abort;
        clear     = abort && (state != ST_IDLE);
        sel2      = hv2 && (!hv1 || (head2 < head1));
        kp_valid  = (state == ST_MERGE) && !abort && !pend1 && !pend2 && (hv1 || hv2);
        take      = kp_valid && kp_ready;
        adv1      = take && !sel2;
        adv2      = take && sel2;
        kp_data   = '0;
        kp_layer  = 1'b0;
        if (kp_valid) begin
            kp_data  = sel2 ? head2 : head1;
            kp_layer = sel2;
        end
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
        case (state)
            ST_IDLE:  if (load) state_nxt = ST_PRIME;
            ST_PRIME: state_nxt = ST_MERGE;
            ST_MERGE: if (exh1 && exh2) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (abort && state != ST_IDLE) state_nxt = ST_IDLE;
    end

    // Accepted-keypoint counter, cleared when a drain starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    kp_total <= '0;
        else if (load) kp_total <= '0;
        else if (take) kp_total <= kp_total + TOT_W'(1);
    end

endmodule

// File: tb/tb_keypoint_merge_scheduler.sv
// Directed bench for keypoint_merge_scheduler with SRAM models and an output scoreboard.
module tb_keypoint_merge_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        kp_ready = 1'b0;
    logic [11:0] kp1_count = '0;
    logic [11:0] kp2_count = '0;
    logic        kp1_re, kp2_re;
    logic [10:0] kp1_addr, kp2_addr;
    logic [18:0] kp1_dout = '0;
    logic [18:0] kp2_dout = '0;
    logic [18:0] kp_data;
    logic        kp_valid, kp_layer, busy, done;
    logic [12:0] kp_total;

    logic [18:0] mem1 [2048];
    logic [18:0] mem2 [2048];
    logic [19:0] sb [$];

    int checks = 0;
    int errors = 0;
    int re1_cnt = 0;
    int re2_cnt = 0;
    int done_cnt = 0;
    logic [10:0] last1 = '0;
    logic [10:0] last2 = '0;

    keypoint_merge_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .kp1_count(kp1_count), .kp2_count(kp2_count),
        .kp1_re(kp1_re), .kp1_addr(kp1_addr), .kp1_dout(kp1_dout),
        .kp2_re(kp2_re), .kp2_addr(kp2_addr), .kp2_dout(kp2_dout),
        .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_data(kp_data),
        .kp_layer(kp_layer), .kp_total(kp_total), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // SRAM models: 1-cycle read latency.
    always @(posedge clk) begin
        if (kp1_re) kp1_dout <= mem1[kp1_addr];
        if (kp2_re) kp2_dout <= mem2[kp2_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] kp(input int r, input int c);
        return {r[8:0], c[9:0]};
    endfunction

    task automatic exp_push(input logic l, input logic [18:0] d);
        sb.push_back({l, d});
    endtask

    // Monitor: read/done bookkeeping and scoreboard compare on each handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (kp1_re) begin re1_cnt++; last1 = kp1_addr; end
            if (kp2_re) begin re2_cnt++; last2 = kp2_addr; end
            if (done) done_cnt++;
            if (kp_valid && kp_ready) begin
                if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
                else chk("kp_out", {kp_layer, kp_data}, sb.pop_front());
            end
        end
    end

    task automatic start_drain();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin @(posedge clk); #1; n++; end
        chk(tag, done, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (kp_valid !== 1'b1 && n < budget) begin @(posedge clk); #1; n++; end
        chk(tag, kp_valid, 1);
    endtask

    task automatic load_basic();
        mem1[0] = kp(5, 10); mem1[1] = kp(7, 3);
        mem2[0] = kp(5, 12); mem2[1] = kp(6, 0);
        kp1_count = 12'd2; kp2_count = 12'd2;
    endtask

    initial begin
        int d0, r1, r2;
        for (int i = 0; i < 2048; i++) begin mem1[i] = '0; mem2[i] = '0; end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", kp_valid, 0);
        chk("rst_re", {kp1_re, kp2_re}, 0);
        chk("rst_total", kp_total, 0);
        rst_n = 1'b1;

        // Both lists empty: done in cycle 3, no reads
        r1 = re1_cnt; r2 = re2_cnt;
        start_drain();
        @(posedge clk); #1 chk("empty_c2_done", done, 0);
        @(posedge clk); #1 chk("empty_c3_done", done, 1);
        @(posedge clk); #1;
        chk("empty_busy_after", busy, 0);
        chk("empty_total", kp_total, 0);
        chk("empty_reads", (re1_cnt - r1) + (re2_cnt - r2), 0);

        // Basic merge
        load_basic();
        kp_ready = 1'b1;
        exp_push(1'b0, kp(5, 10)); exp_push(1'b1, kp(5, 12));
        exp_push(1'b1, kp(6, 0));  exp_push(1'b0, kp(7, 3));
        d0 = done_cnt;
        start_drain();
        @(posedge clk); #1 chk("merge_c2_valid", kp_valid, 0);
        @(posedge clk); #1 chk("merge_c3_valid", kp_valid, 1);
        wait_done("merge_done", 40);
        chk("merge_sb_empty", sb.size(), 0);
        chk("merge_total", kp_total, 4);
        chk("merge_done_pulses", done_cnt - d0, 1);
        chk("merge_busy_after", busy, 0);

        // Tie goes to list 1
        mem1[0] = kp(9, 20); mem2[0] = kp(9, 20);
        kp1_count = 12'd1; kp2_count = 12'd1;
        exp_push(1'b0, kp(9, 20)); exp_push(1'b1, kp(9, 20));
        start_drain();
        wait_done("tie_done", 30);
        chk("tie_sb_empty", sb.size(), 0);
        chk("tie_total", kp_total, 2);

        // Backpressure on list 2 only, count 3
        kp_ready = 1'b0;
        mem2[0] = kp(1, 1); mem2[1] = kp(2, 2); mem2[2] = kp(3, 3);
        kp1_count = 12'd0; kp2_count = 12'd3;
        exp_push(1'b1, kp(1, 1)); exp_push(1'b1, kp(2, 2)); exp_push(1'b1, kp(3, 3));
        r1 = re1_cnt; r2 = re2_cnt;
        start_drain();
        wait_valid("stall_valid", 20);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_valid_hold", kp_valid, 1);
            chk("stall_data_hold", kp_data, kp(1, 1));
            chk("stall_layer_hold", kp_layer, 1);
        end
        chk("stall_reads", re2_cnt - r2, 1);
        kp_ready = 1'b1;
        wait_done("stall_done", 30);
        chk("stall_reads_total", re2_cnt - r2, 3);
        chk("stall_last_addr", last2, 2);
        chk("stall_list1_reads", re1_cnt - r1, 0);
        chk("stall_sb_empty", sb.size(), 0);
        chk("stall_total", kp_total, 3);

        // Count clamp: 4095 -> 2048
        for (int i = 0; i < 2048; i++) begin
            mem1[i] = 19'(i);
            exp_push(1'b0, 19'(i));
        end
        kp1_count = 12'd4095; kp2_count = 12'd0;
        r1 = re1_cnt;
        start_drain();
        wait_done("clamp_done", 5000);
        chk("clamp_reads", re1_cnt - r1, 2048);
        chk("clamp_last_addr", last1, 2047);
        chk("clamp_total", kp_total, 2048);
        chk("clamp_sb_empty", sb.size(), 0);

        // Abort after one accepted keypoint
        load_basic();
        exp_push(1'b0, kp(5, 10));
        d0 = done_cnt;
        start_drain();
        wait_valid("abort_valid", 20);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid_low", kp_valid, 0);
        chk("abort_total", kp_total, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_sb_empty", sb.size(), 0);

        // Asynchronous reset mid-drain
        kp_ready = 1'b0;
        start_drain();
        wait_valid("rstmid_valid", 20);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_valid", kp_valid, 0);
        chk("rstmid_data", {kp_layer, kp_data}, 0);
        chk("rstmid_re", {kp1_re, kp2_re}, 0);
        chk("rstmid_total", kp_total, 0);
        chk("rstmid_done", done, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Fresh drain after reset starts from address 0
        kp_ready = 1'b1;
        exp_push(1'b0, kp(5, 10)); exp_push(1'b1, kp(5, 12));
        exp_push(1'b1, kp(6, 0));  exp_push(1'b0, kp(7, 3));
        start_drain();
        wait_done("again_done", 40);
        chk("again_sb_empty", sb.size(), 0);
        chk("again_total", kp_total, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypoint_merge_scheduler.md
Name: keypoint_merge_scheduler

Overview:
Drains the two keypoint SRAMs filled by the detect/filter stage after each octave pass. Keypoint_1 holds the lower DoG layer pair and keypoint_2 the upper pair. Both lists are raster-ordered; the block reads them through single-port 1-cycle-latency read ports and merges them into one raster-ordered stream. Each streamed keypoint carries a layer tag and goes to the orientation/descriptor stage over a valid/ready handshake.

Parameters:
KP_AW, 11, keypoint SRAM address width (2048 entries)
KP_DW, 19, keypoint word width: {row[8:0], col[9:0]}
KP_MAX, 2048, maximum entries per list; larger counts are clamped

Ports:
clk  in  1  clock (one clock domain)
rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  begin drain; sampled only in IDLE
abort  in  1  synchronous cancel; return to IDLE without done
kp1_count  in  12  number of valid entries in keypoint SRAM 1
kp2_count  in  12  number of valid entries in keypoint SRAM 2
kp1_re  out  1  read enable, SRAM 1
kp1_addr  out  KP_AW  read address, SRAM 1
kp1_dout  in  KP_DW  read data, valid the cycle after kp1_re
kp2_re  out  1  read enable, SRAM 2
kp2_addr  out  KP_AW  read address, SRAM 2
kp2_dout  in  KP_DW  read data, valid the cycle after kp2_re
kp_valid  out  1  stream entry valid
kp_ready  in  1  consumer accepts
kp_data  out  KP_DW  {row, col}
kp_layer  out  1  0 = from list 1, 1 = from list 2
kp_total  out  13  running count of keypoints accepted this drain
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when both lists are exhausted

Behaviour:
- Reset: state=IDLE; all outputs 0; read pointers 0; head registers and valid/pending flags cleared. Reset mid-drain discards all progress.
- FSM: IDLE -> PRIME -> MERGE -> DONE -> IDLE.
- IDLE: on start, latch min(kpN_count, KP_MAX) into remN; clear kp_total; go to PRIME.
- PRIME: assert kpN_re (addr 0) only for lists with remN>0; set pendingN for those lists; go to MERGE.
- pendingN: kpN_dout is captured into headN at the end of the pending cycle; headN_v=1 and pendingN=0 next cycle.
- MERGE:
  - kp_valid = !pending1 && !pending2 && (head1_v || head2_v).
  - Selection: if only one head is valid, select it. If both are valid, select the smaller unsigned 19-bit {row,col}. On a tie, select list 1.
  - kp_data and kp_layer are driven from head registers only; no combinational path from kpN_dout.
  - kp_valid stays high and kp_data stays stable until the handshake (kp_valid && kp_ready).
  - On handshake from list N: kp_total+1; remN-1; if remN (old) > 1, issue kpN_re at the next address in the same cycle and set pendingN; otherwise clear headN_v.
  - Throughput: one keypoint per 2 cycles (bubble in the pending cycle).
  - Exit to DONE when remaining count, headN_v and pendingN are all 0 for both lists.
- DONE: done=1 for exactly one cycle; busy=1; go to IDLE.
- Latency: with both lists empty, done is high in cycle 3 after the start cycle (start = cycle 0). With a non-empty list, first kp_valid is in cycle 3.
- kpN_addr increments only on issued reads and never exceeds KP_MAX-1; no wrap.
- abort: in any non-IDLE state, the next state is IDLE. Clear flags and deassert kp_valid. No done pulse. An outstanding read is discarded.
- start while not IDLE: ignored. start and abort in the same cycle in IDLE: abort wins, stay in IDLE.
- Counts are sampled only at start; later changes are ignored.

Decomposition:
- Shared package:
  - KP_AW, KP_DW, KP_MAX.
  - Field slices ROW_MSB=18, ROW_LSB=10, COL_MSB=9, COL_LSB=0.
  - State encoding ST_IDLE/ST_PRIME/ST_MERGE/ST_DONE.
- One sub-module, kp_list_reader, instantiated twice. It contains remaining counter, address pointer, pending flag, head register and head_v. Inputs: load/count, advance. Outputs: head, head_v, pending, exhausted.
- Compare/select logic and FSM live in the top.

Test Plan:
- kp1_count=0, kp2_count=0, start -> no kpN_re; done pulse in cycle 3; kp_total=0; busy 0 after.
- List1={(5,10),(7,3)}, list2={(5,12),(6,0)}, kp_ready=1 -> output order (5,10)L0, (5,12)L1, (6,0)L1, (7,3)L0; kp_total=4; single done pulse.
- Tie: list1={(9,20)}, list2={(9,20)} -> L0 emitted first, then L1.
- kp_ready low for 5 cycles with kp_valid high -> kp_data and kp_layer stable; no extra kpN_re; list2 only, count=3 -> kp2_addr 0,1,2 and never 3.
- kp1_count=4095 -> clamped to 2048 reads; kp1_addr peaks at 2047; kp_total=2048.
- abort during MERGE after 1 accepted keypoint -> IDLE next cycle, no done. Assert rst_n low mid-drain -> all outputs 0 asynchronously. A new start then drains from addr 0.
